// File: rtl/ysyx_25060173_wb_arbiter_pkg.sv
// Shared definitions for the write-back arbiter and its scoreboard.
// Optional feature macro: YSYX_25060173_WBARB_RR_EN (round-robin arbitration).
package ysyx_25060173_wb_arbiter_pkg;

    localparam int unsigned WB_ADDR_WIDTH = 5;
    localparam int unsigned WB_DATA_WIDTH = 32;

    localparam logic REQ_EXU = 1'b0;
    localparam logic REQ_LSU = 1'b1;

    typedef struct packed {
        logic                     valid;
        logic [WB_ADDR_WIDTH-1:0] addr;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/ysyx_25060173_wb_scoreboard.sv
// Per-register pending-write scoreboard: one set port, one clear port, two query ports.
// Entry 0 never becomes busy.
module ysyx_25060173_wb_scoreboard
    import ysyx_25060173_wb_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = WB_ADDR_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       set_en_i,
    input  logic [ADDR_WIDTH-1:0]      set_addr_i,
    input  logic                       clr_en_i,
    input  logic [ADDR_WIDTH-1:0]      clr_addr_i,
    input  logic [ADDR_WIDTH-1:0]      qa_addr_i,
    output logic                       qa_busy_o,
    input  logic [ADDR_WIDTH-1:0]      qb_addr_i,
    output logic                       qb_busy_o,
    output logic [(1<<ADDR_WIDTH)-1:0] busy_o
);

    localparam int unsigned NumRegs = 1 << ADDR_WIDTH;

    logic [NumRegs-1:0] busy_q, busy_d;

    // Clear first so a set on a different register in the same cycle survives.
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) begin
            busy_d[clr_addr_i] = 1'b0;
        end
        if (set_en_i) begin
            busy_d[set_addr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign qa_busy_o = (qa_addr_i != '0) && busy_q[qa_addr_i];
    assign qb_busy_o = (qb_addr_i != '0) && busy_q[qb_addr_i];
    assign busy_o    = busy_q;

endmodule

// File: rtl/ysyx_25060173_wb_arbiter.sv
// Write-back scheduler: arbitrates EXU/LSU onto the single register-file write port.
// Define YSYX_25060173_WBARB_RR_EN for round-robin; otherwise the LSU has fixed priority.
module ysyx_25060173_wb_arbiter
    import ysyx_25060173_wb_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = WB_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_valid_i,
    input  logic [ADDR_WIDTH-1:0] issue_rd_i,
    output logic                  issue_ready_o,
    input  logic                  req0_valid_i,
    input  logic [ADDR_WIDTH-1:0] req0_addr_i,
    input  logic [DATA_WIDTH-1:0] req0_data_i,
    output logic                  req0_ready_o,
    input  logic                  req1_valid_i,
    input  logic [ADDR_WIDTH-1:0] req1_addr_i,
    input  logic [DATA_WIDTH-1:0] req1_data_i,
    output logic                  req1_ready_o,
    output logic                  rf_we_o,
    output logic [ADDR_WIDTH-1:0] rf_waddr_o,
    output logic [DATA_WIDTH-1:0] rf_wdata_o,
    input  logic [ADDR_WIDTH-1:0] rs1_addr_i,
    input  logic [ADDR_WIDTH-1:0] rs2_addr_i,
    output logic                  rs1_busy_o,
    output logic                  rs2_busy_o
);

    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } req_t;

    req_t req0, req1, win;
    logic gnt0, gnt1, gnt_sel;

    logic                  rf_we_q, rf_we_d;
    logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;

    logic [(1<<ADDR_WIDTH)-1:0] busy;
    logic                       issue_set;

    assign req0 = '{valid: req0_valid_i, addr: req0_addr_i, data: req0_data_i};
    assign req1 = '{valid: req1_valid_i, addr: req1_addr_i, data: req1_data_i};

`ifdef YSYX_25060173_WBARB_RR_EN
    logic last_q, last_d;

    // On contention the requester not granted last time wins.
    assign gnt1 = req1.valid && (!req0.valid || (last_q == REQ_EXU));
    assign gnt0 = req0.valid && !gnt1;

    always_comb begin
        last_d = last_q;
        if (gnt0 || gnt1) begin
            last_d = gnt_sel;
        end
    end

    // Reset value makes req0 win the first contended cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= REQ_LSU;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign gnt1 = req1.valid;
    assign gnt0 = req0.valid && !req1.valid;
`endif

    assign gnt_sel      = gnt1 ? REQ_LSU : REQ_EXU;
    assign win          = (gnt_sel == REQ_LSU) ? req1 : req0;
    assign req0_ready_o = gnt0;
    assign req1_ready_o = gnt1;

    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (gnt0 || gnt1) begin
            rf_we_d    = (win.addr != '0);
            rf_waddr_d = win.addr;
            rf_wdata_d = win.data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_we_o    = rf_we_q;
    assign rf_waddr_o = rf_waddr_q;
    assign rf_wdata_o = rf_wdata_q;

    // WAW stall: a destination with a write outstanding cannot be re-issued.
    assign issue_ready_o = !((issue_rd_i != '0) && busy[issue_rd_i]);
    assign issue_set     = issue_valid_i && issue_ready_o && (issue_rd_i != '0);

    ysyx_25060173_wb_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_en_i   (issue_set),
        .set_addr_i (issue_rd_i),
        .clr_en_i   (rf_we_q),
        .clr_addr_i (rf_waddr_q),
        .qa_addr_i  (rs1_addr_i),
        .qa_busy_o  (rs1_busy_o),
        .qb_addr_i  (rs2_addr_i),
        .qb_busy_o  (rs2_busy_o),
        .busy_o     (busy)
    );

endmodule

// File: doc/ysyx_25060173_wb_arbiter.md
# ysyx_25060173_wb_arbiter

Write-back scheduler for the 32-entry register file: shares the register file's single write port between two write-back requesters (EXU and LSU) using a valid/ready handshake. It keeps a per-register pending-write scoreboard so decode can stall on RAW/WAW hazards. It sits between the execute/memory stages and the register file. Its registered outputs drive the register file's write enable, write address and write data directly.

## Interface
Parameters:
- ADDR_WIDTH, 5, register index width (register count = 1 << ADDR_WIDTH)
- DATA_WIDTH, 32, write data width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- issue_valid  in  1  decode wants to mark a destination register pending
- issue_rd  in  ADDR_WIDTH  destination register of the issuing instruction
- issue_ready  out  1  issue accepted this cycle
- req0_valid  in  1  EXU write-back request
- req0_addr  in  ADDR_WIDTH  EXU destination register
- req0_data  in  DATA_WIDTH  EXU result
- req0_ready  out  1  EXU request granted this cycle
- req1_valid, req1_addr, req1_data, req1_ready  same as req0, for the LSU
- rf_we  out  1  register file write enable
- rf_waddr  out  ADDR_WIDTH  register file write address
- rf_wdata  out  DATA_WIDTH  register file write data
- rs1_addr, rs2_addr  in  ADDR_WIDTH  decode source-register queries
- rs1_busy, rs2_busy  out  1  queried register has a write outstanding

## Operation
- Scoreboard: busy[N-1:0]. busy[0] is hard-wired to 0.
- Issue handshake:
  - issue_ready = !(issue_rd != 0 && busy[issue_rd]). This is the WAW stall.
  - On issue_valid && issue_ready with issue_rd != 0, set busy[issue_rd] at the clock edge.
  - Issue to x0 is accepted and sets nothing.
- Write-back handshake:
  - A requester holds valid, addr and data stable until ready.
  - ready is combinational, and at most one of req0_ready/req1_ready is high per cycle.
  - A transfer occurs when valid && ready.
- Arbitration:
  - Only one valid: that requester is granted.
  - Both valid: granted per the configured policy (see Configuration).
- Output stage:
  - The granted request is captured into rf_we/rf_waddr/rf_wdata at the edge.
  - rf_we = 1 only if the granted addr != 0. A write to x0 completes its handshake but produces rf_we = 0.
  - With no grant, rf_we = 0 next cycle; rf_waddr/rf_wdata hold their previous values.
- Commit: in the cycle rf_we = 1, busy[rf_waddr] clears at the closing edge, the same edge the register file writes.
- Simultaneous events:
  - Commit clear and issue set on the same register cannot coincide: issue is blocked while busy.
  - Clear and set on different registers both take effect.
  - A write-back to a non-busy register is legal: data is written and the clear is a no-op.
- rsN_busy = (rsN_addr != 0) && busy[rsN_addr], combinational from registered state only.

## Timing
- Reset (async assert, sync-safe deassert): busy = 0, rf_we = 0, rf_waddr = 0, rf_wdata = 0, round-robin pointer favours req0.
- Reset asserted mid-operation discards the pending output-stage write and all scoreboard state.
- Grant to rf_we: 1 cycle. Grant to busy clear visible on rsN_busy: 2 cycles.
- Throughput: one write-back per cycle. The register file always accepts, so the output stage never stalls.
- No combinational path from req*_data to rf_* outputs.

## Configuration
- YSYX_25060173_WBARB_RR_EN defined: round-robin arbitration.
  - A 1-bit pointer records the last granted requester.
  - When both are valid, the other requester wins.
  - The pointer updates only on a grant.
- Not defined: fixed priority. req1 (LSU) always wins when both are valid, and the pointer logic is absent.

## Structure
- Shared package holds:
  - ADDR_WIDTH/DATA_WIDTH defaults
  - requester index constants REQ_EXU = 0, REQ_LSU = 1
  - a write-back request struct {valid, addr, data}
- One natural sub-module: ysyx_25060173_wb_scoreboard (busy vector, set/clear ports, two query ports).
- Arbitration and the output register stay in the top.

## Test plan
- Reset then idle: rf_we = 0, all busy = 0, issue_ready = 1 for any rd.
- Issue rd = 5, then req0 writes x5 = 0xDEADBEEF:
  - rs1_addr = 5 reads busy = 1 until 2 cycles after grant.
  - rf_we = 1, rf_waddr = 5, rf_wdata = 0xDEADBEEF one cycle after grant.
- Issue rd = 7 twice back-to-back: second issue_ready = 0 until x7 commits.
- req0 and req1 valid together for 4 cycles with different addresses:
  - RR_EN defined: grants alternate starting with req0 after reset.
  - Not defined: req1 granted every cycle and req0 starved.
- req1 writes x0 = 0x1234: req1_ready = 1, next cycle rf_we = 0, busy[0] stays 0.
- Assert rst_n low in the cycle after a grant: rf_we = 0 immediately (asynchronous), busy all cleared.
